// File: rtl/ov7670_pattern_tx.sv
// ov7670_pattern_tx: emulates an OV7670 RGB444 camera (PCLK/VSYNC/HREF/D[7:0]) from internal test patterns.
// Latency: IDLE->VSYNC one clk after enable_i; first byte (VSYNC high) on the PCLK fall two clks later.
// Backpressure: none, free-running source; define OV7670_TX_BYTE_SWAP_EN to send {G,B} before {0,R}.
module ov7670_pattern_tx #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int HBLANK_PCLKS   = 144,
    parameter int VSYNC_LINES    = 3,
    parameter int VBACK_LINES    = 17,
    parameter int VFRONT_LINES   = 10
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic [1:0]  pattern_sel_i,
    input  logic [11:0] solid_rgb_i,
    output logic        pclk_cmos_o,
    output logic        vsync_cmos_o,
    output logic        href_cmos_o,
    output logic [7:0]  pixel_data_cmos_o,
    output logic        frame_done_o
);
    localparam int ACTIVE_BYTES = 2 * ACTIVE_COLUMNS;
    localparam int LINE_PCLKS   = ACTIVE_BYTES + HBLANK_PCLKS;
    localparam int HCW          = $clog2(LINE_PCLKS);
    localparam int XW           = $clog2(ACTIVE_COLUMNS);
    localparam int LCW          = 16;
    localparam int BAR_COLS     = ACTIVE_COLUMNS / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            phase_q, phase_d;
    logic [HCW-1:0]  hcnt_q, hcnt_d;
    logic [LCW-1:0]  lcnt_q, lcnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [1:0]      pat_q, pat_d;
    logic [11:0]     solid_q, solid_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;

    logic [15:0]     px_x;
    logic [15:0]     bar_idx;
    logic [11:0]     rgb;
    logic            in_active;
    logic [7:0]      pix_byte;
    logic [LCW-1:0]  last_line;

    // Colour of the pixel addressed by the current byte position (y is the active line count)
    always_comb begin
        px_x    = 16'(hcnt_q >> 1);
        bar_idx = px_x / 16'(BAR_COLS);
        rgb     = 12'h000;
        case (pat_q)
            2'd0: begin
                case (bar_idx)
                    16'd0:   rgb = 12'hFFF;
                    16'd1:   rgb = 12'hFF0;
                    16'd2:   rgb = 12'h0FF;
                    16'd3:   rgb = 12'h0F0;
                    16'd4:   rgb = 12'hF0F;
                    16'd5:   rgb = 12'hF00;
                    16'd6:   rgb = 12'h00F;
                    default: rgb = 12'h000;
                endcase
            end
            2'd1:    rgb = {3{px_x[XW-1 -: 4]}};
            2'd2:    rgb = solid_q;
            // origin square is white on even frames, black on odd ones
            default: rgb = (px_x[5] ^ lcnt_q[5] ^ frame_cnt_q[0]) ? 12'h000 : 12'hFFF;
        endcase
    end

    // Byte selection within the pixel, active-window decode and per-state line budget
    always_comb begin
        in_active = (state_q == S_ACTIVE) && (hcnt_q < HCW'(ACTIVE_BYTES));
`ifdef OV7670_TX_BYTE_SWAP_EN
        pix_byte  = hcnt_q[0] ? {4'h0, rgb[11:8]} : rgb[7:0];
`else
        pix_byte  = hcnt_q[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
`endif
        case (state_q)
            S_VSYNC:  last_line = LCW'(VSYNC_LINES - 1);
            S_VBACK:  last_line = LCW'(VBACK_LINES - 1);
            S_ACTIVE: last_line = LCW'(ACTIVE_ROWS - 1);
            S_VFRONT: last_line = LCW'(VFRONT_LINES - 1);
            default:  last_line = '0;
        endcase
    end

    // Frame FSM: outputs and position advance only on the PCLK falling edge (phase 1->0)
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hcnt_d      = hcnt_q;
        lcnt_d      = lcnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        solid_d     = solid_q;
        vsync_d     = vsync_q;
        href_d      = href_q;
        data_d      = data_q;
        done_d      = 1'b0;
        if (state_q == S_IDLE) begin
            phase_d = 1'b0;
            hcnt_d  = '0;
            lcnt_d  = '0;
            vsync_d = 1'b0;
            href_d  = 1'b0;
            data_d  = 8'h00;
            if (enable_i) begin
                state_d = S_VSYNC;
                pat_d   = pattern_sel_i;
                solid_d = solid_rgb_i;
            end
        end else begin
            phase_d = ~phase_q;
            if (phase_q) begin
                vsync_d = (state_q == S_VSYNC);
                href_d  = in_active;
                data_d  = in_active ? pix_byte : 8'h00;
                if (hcnt_q == HCW'(LINE_PCLKS - 1)) begin
                    hcnt_d = '0;
                    if (lcnt_q == last_line) begin
                        lcnt_d = '0;
                        case (state_q)
                            S_VSYNC:  state_d = S_VBACK;
                            S_VBACK:  state_d = S_ACTIVE;
                            S_ACTIVE: state_d = S_VFRONT;
                            default: begin
                                done_d      = 1'b1;
                                frame_cnt_d = frame_cnt_q + 16'd1;
                                if (enable_i) begin
                                    state_d = S_VSYNC;
                                    pat_d   = pattern_sel_i;
                                    solid_d = solid_rgb_i;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                        endcase
                    end else begin
                        lcnt_d = lcnt_q + LCW'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q + HCW'(1);
                end
            end
        end
    end

    // State and output registers; reset clears every output immediately
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            frame_cnt_q <= 16'd0;
            pat_q       <= 2'd0;
            solid_q     <= 12'h000;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            frame_cnt_q <= frame_cnt_d;
            pat_q       <= pat_d;
            solid_q     <= solid_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    assign pclk_cmos_o       = phase_q;
    assign vsync_cmos_o      = vsync_q;
    assign href_cmos_o       = href_q;
    assign pixel_data_cmos_o = data_q;
    assign frame_done_o      = done_q;

endmodule
